// File: rtl/sprite_pkg.sv
// Shared widths and stream layout for the sprite loader and the sprite renderer.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAL_LO = 2'd1,
    PAL_HI = 2'd2,
    PIXELS = 2'd3
  } state_t;

  localparam int COLOR_W = 12;  // {r,g,b}, 4 bits each
  localparam int INDEX_W = 8;   // palette index stored per pixel

  // Palette entries arrive as two bytes, low byte first.
  localparam int PAL_BYTES_PER_ENTRY = 2;
  localparam int PAL_LO_BYTE         = 0;
  localparam int PAL_HI_BYTE         = 1;
  localparam int PAL_HI_BITS         = COLOR_W - 8;  // used bits of the high byte

endpackage

// File: rtl/sprite_loader.sv
// Byte-stream writer for the palette and image BRAMs: palette section first,
// then pixel indices in raster order. Writes are registered single-cycle strobes.
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int HEIGHT    = 256,
  parameter int PAL_DEPTH = 256,
  localparam int IMG_AW   = $clog2(WIDTH * HEIGHT)
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic               abort_in,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid_in,
  output logic               byte_ready_out,
  output logic [7:0]         pal_addr_out,
  output logic [COLOR_W-1:0] pal_data_out,
  output logic               pal_we_out,
  output logic [IMG_AW-1:0]  img_addr_out,
  output logic [INDEX_W-1:0] img_data_out,
  output logic               img_we_out,
  output logic               busy_out,
  output logic               done_out
);

  state_t            state, next_state;
  logic [7:0]        pal_cnt;
  logic [IMG_AW-1:0] img_cnt;
  logic [7:0]        pal_lo;

  logic accept, lo_ld, pal_wr, img_wr, pal_last, img_last, finish;

  // The upper nibble of a palette high byte carries no colour information.
  logic unused_hi_nib;
  assign unused_hi_nib = ^byte_in[7:PAL_HI_BITS];

  // Ready and busy depend on state only, so the source never sees a
  // combinational path from its own valid back to ready.
  assign byte_ready_out = (state != IDLE);
  assign busy_out       = (state != IDLE);

  assign accept   = byte_valid_in && byte_ready_out;
  assign pal_last = (pal_cnt == 8'(PAL_DEPTH - 1));
  assign img_last = (img_cnt == IMG_AW'(WIDTH * HEIGHT - 1));

  // Abort outranks accept, so a byte taken in the abort cycle never writes.
  assign lo_ld  = (state == PAL_LO) && accept && !abort_in;
  assign pal_wr = (state == PAL_HI) && accept && !abort_in;
  assign img_wr = (state == PIXELS) && accept && !abort_in;
  assign finish = img_wr && img_last;

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start_in) next_state = PAL_LO;
      PAL_LO: if (abort_in) next_state = IDLE;
              else if (accept) next_state = PAL_HI;
      PAL_HI: if (abort_in) next_state = IDLE;
              else if (accept) next_state = pal_last ? PIXELS : PAL_LO;
      PIXELS: if (abort_in) next_state = IDLE;
              else if (accept && img_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  // Counters and registered write ports; addr/data hold while strobes are low.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      pal_cnt      <= '0;
      img_cnt      <= '0;
      pal_lo       <= '0;
      pal_addr_out <= '0;
      pal_data_out <= '0;
      pal_we_out   <= 1'b0;
      img_addr_out <= '0;
      img_data_out <= '0;
      img_we_out   <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      pal_we_out <= pal_wr;
      img_we_out <= img_wr;
      done_out   <= finish;
      if (state == IDLE && start_in) begin
        pal_cnt <= '0;
        img_cnt <= '0;
      end
      if (lo_ld) pal_lo <= byte_in;
      if (pal_wr) begin
        pal_addr_out <= pal_cnt;
        pal_data_out <= {byte_in[PAL_HI_BITS-1:0], pal_lo};
        if (!pal_last) pal_cnt <= pal_cnt + 8'd1;
      end
      if (img_wr) begin
        img_addr_out <= img_cnt;
        img_data_out <= byte_in;
        if (!img_last) img_cnt <= img_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Directed bench for sprite_loader with a 4x2 sprite and a 2-entry palette.
module tb_sprite_loader;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        abort_in = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid_in = 1'b0;
  logic        byte_ready_out;
  logic [7:0]  pal_addr_out;
  logic [11:0] pal_data_out;
  logic        pal_we_out;
  logic [2:0]  img_addr_out;
  logic [7:0]  img_data_out;
  logic        img_we_out;
  logic        busy_out;
  logic        done_out;

  int tests = 0;
  int failed = 0;

  logic [7:0]  stream [12] = '{8'h34, 8'hF2, 8'hCD, 8'h0A,
                               8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
  logic [11:0] pal_exp [2] = '{12'h234, 12'hACD};

  sprite_loader #(.WIDTH(4), .HEIGHT(2), .PAL_DEPTH(2)) dut (
    .pixel_clk_in  (pixel_clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .abort_in      (abort_in),
    .byte_in       (byte_in),
    .byte_valid_in (byte_valid_in),
    .byte_ready_out(byte_ready_out),
    .pal_addr_out  (pal_addr_out),
    .pal_data_out  (pal_data_out),
    .pal_we_out    (pal_we_out),
    .img_addr_out  (img_addr_out),
    .img_data_out  (img_data_out),
    .img_we_out    (img_we_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic [7:0] b, input logic v, input logic st, input logic ab);
    byte_in = b; byte_valid_in = v; start_in = st; abort_in = ab;
    @(posedge pixel_clk_in); #1;
    byte_valid_in = 1'b0; start_in = 1'b0; abort_in = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"},  32'(byte_ready_out), 32'd0);
    chk({tag, "_busy"},   32'(busy_out),       32'd0);
    chk({tag, "_done"},   32'(done_out),       32'd0);
    chk({tag, "_pwe"},    32'(pal_we_out),     32'd0);
    chk({tag, "_paddr"},  32'(pal_addr_out),   32'd0);
    chk({tag, "_pdata"},  32'(pal_data_out),   32'd0);
    chk({tag, "_iwe"},    32'(img_we_out),     32'd0);
    chk({tag, "_iaddr"},  32'(img_addr_out),   32'd0);
    chk({tag, "_idata"},  32'(img_data_out),   32'd0);
  endtask

  task automatic chk_pal(input string tag, input logic we, input logic [7:0] a, input logic [11:0] d);
    chk({tag, "_pwe"},   32'(pal_we_out),   32'(we));
    chk({tag, "_iwe"},   32'(img_we_out),   32'd0);
    chk({tag, "_paddr"}, 32'(pal_addr_out), 32'(a));
    chk({tag, "_pdata"}, 32'(pal_data_out), 32'(d));
  endtask

  task automatic chk_img(input string tag, input logic we, input logic [2:0] a, input logic [7:0] d,
                         input logic dn, input logic bsy);
    chk({tag, "_iwe"},   32'(img_we_out),   32'(we));
    chk({tag, "_pwe"},   32'(pal_we_out),   32'd0);
    chk({tag, "_iaddr"}, 32'(img_addr_out), 32'(a));
    chk({tag, "_idata"}, 32'(img_data_out), 32'(d));
    chk({tag, "_done"},  32'(done_out),     32'(dn));
    chk({tag, "_busy"},  32'(busy_out),     32'(bsy));
  endtask

  task automatic load_pal;
    cyc(stream[0], 1'b1, 1'b0, 1'b0); chk_pal("lp0", 1'b0, 8'd1, 12'hACD);
    cyc(stream[1], 1'b1, 1'b0, 1'b0); chk_pal("lp1", 1'b1, 8'd0, 12'h234);
    cyc(stream[2], 1'b1, 1'b0, 1'b0); chk_pal("lp2", 1'b0, 8'd0, 12'h234);
    cyc(stream[3], 1'b1, 1'b0, 1'b0); chk_pal("lp3", 1'b1, 8'd1, 12'hACD);
  endtask

  initial begin
    // Reset state
    #2 chk_zero("rst");
    #10 rst_in = 1'b0;
    @(posedge pixel_clk_in); #1;
    chk_zero("post_rst");

    // Valid high in IDLE without start: nothing accepted, nothing written
    for (int i = 0; i < 3; i++) begin
      cyc(8'h77, 1'b1, 1'b0, 1'b0);
      chk_zero("idle_valid");
    end

    // Full-throughput load
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    chk("t1_busy", 32'(busy_out), 32'd1);
    chk("t1_ready", 32'(byte_ready_out), 32'd1);
    cyc(stream[0], 1'b1, 1'b0, 1'b0); chk_pal("t1_p0", 1'b0, 8'd0, 12'h000);
    cyc(stream[1], 1'b1, 1'b0, 1'b0); chk_pal("t1_p1", 1'b1, 8'd0, 12'h234);
    cyc(stream[2], 1'b1, 1'b0, 1'b0); chk_pal("t1_p2", 1'b0, 8'd0, 12'h234);
    cyc(stream[3], 1'b1, 1'b0, 1'b0); chk_pal("t1_p3", 1'b1, 8'd1, 12'hACD);
    for (int i = 0; i < 8; i++) begin
      cyc(stream[4+i], 1'b1, 1'b0, 1'b0);
      chk_img("t1_px", 1'b1, 3'(i), 8'(i), i == 7, i != 7);
    end
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    chk_img("t1_after", 1'b0, 3'd7, 8'd7, 1'b0, 1'b0);
    chk("t1_ready_after", 32'(byte_ready_out), 32'd0);

    // Same stream with a gap cycle after every byte
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc(stream[k], 1'b1, 1'b0, 1'b0);
      if (k < 4) begin
        if (k % 2 == 1) chk_pal("t2_pw", 1'b1, 8'(k / 2), pal_exp[k / 2]);
        else            chk("t2_pwe_lo", 32'(pal_we_out), 32'd0);
      end else begin
        chk_img("t2_px", 1'b1, 3'(k - 4), 8'(k - 4), k == 11, k != 11);
      end
      cyc(8'hEE, 1'b0, 1'b0, 1'b0);
      chk("t2_gap_pwe", 32'(pal_we_out), 32'd0);
      chk("t2_gap_iwe", 32'(img_we_out), 32'd0);
      chk("t2_gap_done", 32'(done_out), 32'd0);
      chk("t2_gap_busy", 32'(busy_out), 32'(k != 11));
    end

    // Abort on the cycle the third pixel byte is accepted
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    load_pal();
    cyc(8'h00, 1'b1, 1'b0, 1'b0); chk_img("t3_px0", 1'b1, 3'd0, 8'd0, 1'b0, 1'b1);
    cyc(8'h01, 1'b1, 1'b0, 1'b0); chk_img("t3_px1", 1'b1, 3'd1, 8'd1, 1'b0, 1'b1);
    cyc(8'h02, 1'b1, 1'b0, 1'b1); chk_img("t3_abort", 1'b0, 3'd1, 8'd1, 1'b0, 1'b0);
    chk("t3_ready", 32'(byte_ready_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h03, 1'b1, 1'b0, 1'b0);
      chk_img("t3_idle", 1'b0, 3'd1, 8'd1, 1'b0, 1'b0);
    end

    // Fresh load after abort restarts at addr 0; start mid-PIXELS is ignored
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    load_pal();
    for (int i = 0; i < 8; i++) begin
      cyc(8'h10 + 8'(i), 1'b1, i == 3, 1'b0);
      chk_img("t4_px", 1'b1, 3'(i), 8'h10 + 8'(i), i == 7, i != 7);
    end
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    chk("t4_done_once", 32'(done_out), 32'd0);

    // Asynchronous reset mid-PAL_HI clears everything without a clock edge
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    cyc(8'h34, 1'b1, 1'b0, 1'b0);
    chk("t5_pre_busy", 32'(busy_out), 32'd1);
    #2 rst_in = 1'b1;
    #1 chk_zero("t5_async");
    #2 rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(8'h5A, 1'b1, 1'b0, 1'b0);
      chk_zero("t5_idle");
    end
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    chk("t5_restart_ready", 32'(byte_ready_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
